// File: rtl/video_in_store_if.sv
// Pixel FIFO read port and bus-master write port of video_in_store.
// wb_stb is the request valid and wb_ack its completion; wb_adr/wb_dat_o/wb_we stay stable until ack.
interface video_in_store_if;
    logic [7:0]  fifo_count;
    logic [31:0] fifo_data;
    logic        fifo_r_e;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic        wb_ack;

    modport master (
        input  fifo_count, fifo_data, wb_ack,
        output fifo_r_e, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o
    );

    modport slave (
        output fifo_count, fifo_data, wb_ack,
        input  fifo_r_e, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o
    );
endinterface

// File: rtl/video_in_store.sv
// Moves captured pixel words from a FIFO into a frame buffer in bursts of BURST_LEN bus writes.
// Define VIDEO_IN_STORE_DBUF_EN to ping-pong between base_addr_0 and base_addr_1 per frame.
module video_in_store #(
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 76800
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             enable,
    input  logic [31:0]      base_addr_0,
    input  logic [31:0]      base_addr_1,
    video_in_store_if.master bus,
    output logic             frame_done,
    output logic             frame_idx,
    output logic [2:0]       dbg_state
);
    localparam int          BW        = $clog2(BURST_LEN);
    localparam logic [8:0]  BURST_CNT = 9'(BURST_LEN);
    localparam logic [16:0] FRAME_END = 17'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] wc_q, wc_d, wc_inc;
    logic        fifo_r_e_q, fifo_r_e_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        wb_stb_q, wb_stb_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_idx_q, frame_idx_d;
    logic        wbuf_q, wbuf_d;
    logic [31:0] base;
    logic        burst_end;

`ifdef VIDEO_IN_STORE_DBUF_EN
    assign base = wbuf_q ? base_addr_1 : base_addr_0;
`else
    logic unused_base_addr_1;
    assign unused_base_addr_1 = ^base_addr_1;
    assign base = base_addr_0;
`endif

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        fifo_r_e_d   = 1'b0;
        wb_cyc_d     = wb_cyc_q;
        wb_stb_d     = wb_stb_q;
        wb_we_d      = wb_we_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;
        frame_done_d = 1'b0;
        frame_idx_d  = frame_idx_q;
        wbuf_d       = wbuf_q;
        wc_inc       = wc_q + 17'd1;
        burst_end    = (wc_inc[BW-1:0] == '0);
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    wc_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Disable wins over a ready FIFO: the partial frame is dropped here.
                if (!enable) begin
                    wc_d    = '0;
                    state_d = S_IDLE;
                end else if ({1'b0, bus.fifo_count} >= BURST_CNT) begin
                    fifo_r_e_d = 1'b1;
                    wb_cyc_d   = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                wb_dat_d = bus.fifo_data;
                wb_adr_d = base + {13'd0, wc_q, 2'b00};
                wb_stb_d = 1'b1;
                wb_we_d  = 1'b1;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (bus.wb_ack) begin
                    wc_d     = wc_inc;
                    wb_stb_d = 1'b0;
                    wb_we_d  = 1'b0;
                    if (wc_inc == FRAME_END) begin
                        wb_cyc_d     = 1'b0;
                        frame_done_d = 1'b1;
                        frame_idx_d  = wbuf_q;
                        state_d      = S_DONE;
                    end else if (burst_end) begin
                        wb_cyc_d = 1'b0;
                        state_d  = S_WAIT;
                    end else begin
                        fifo_r_e_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                wc_d = '0;
`ifdef VIDEO_IN_STORE_DBUF_EN
                wbuf_d = ~wbuf_q;
`endif
                state_d = enable ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= S_IDLE;
            wc_q         <= '0;
            fifo_r_e_q   <= 1'b0;
            wb_cyc_q     <= 1'b0;
            wb_stb_q     <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_adr_q     <= '0;
            wb_dat_q     <= '0;
            frame_done_q <= 1'b0;
            frame_idx_q  <= 1'b0;
            wbuf_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            fifo_r_e_q   <= fifo_r_e_d;
            wb_cyc_q     <= wb_cyc_d;
            wb_stb_q     <= wb_stb_d;
            wb_we_q      <= wb_we_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            frame_done_q <= frame_done_d;
            frame_idx_q  <= frame_idx_d;
            wbuf_q       <= wbuf_d;
        end
    end

    assign bus.fifo_r_e = fifo_r_e_q;
    assign bus.wb_cyc   = wb_cyc_q;
    assign bus.wb_stb   = wb_stb_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_adr   = wb_adr_q;
    assign bus.wb_dat_o = wb_dat_q;
    assign frame_done   = frame_done_q;
    assign frame_idx    = frame_idx_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_video_in_store.sv
// Scoreboard bench for video_in_store: FIFO and bus-slave models, expected address/data queues.
// Uses a short frame so complete frames fit in a brief run.
module tb_video_in_store;
  localparam int BL = 16;
  localparam int FW = 64;
`ifdef VIDEO_IN_STORE_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk, rst, enable, frame_done, frame_idx;
  logic [31:0] base_addr_0, base_addr_1;
  logic [2:0] dbg_state;
  video_in_store_if bus();

  video_in_store #(.BURST_LEN(BL), .FRAME_WORDS(FW)) dut (
    .clk(clk), .RST(rst), .enable(enable),
    .base_addr_0(base_addr_0), .base_addr_1(base_addr_1),
    .bus(bus), .frame_done(frame_done), .frame_idx(frame_idx),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_adr_q[$];
  logic [31:0] idx_q[$];
  int exp_word = 0;
  logic exp_buf = 1'b0;
  int reads = 0, ack_cnt = 0, done_cycles = 0, wait_cnt = 0;
  bit stall_en = 0, spurious = 0;
  logic [31:0] cap_adr, cap_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_base(input logic b);
    return (DBUF && b) ? base_addr_1 : base_addr_0;
  endfunction

  // FIFO and bus-slave models plus scoreboard, acting on the falling edge
  initial begin
    int delay;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (bus.fifo_r_e) begin
        reads++;
        check("rd_nonempty", 32'(fifo_q.size() > 0), 32'd1);
        if (fifo_q.size() > 0) begin
          w = fifo_q.pop_front();
          bus.fifo_data = w;
          exp_q.push_back(w);
          exp_adr_q.push_back(model_base(exp_buf) + (32'(exp_word) << 2));
          exp_word++;
          if (exp_word == FW) begin
            idx_q.push_back({31'd0, exp_buf});
            exp_word = 0;
            if (DBUF) exp_buf = ~exp_buf;
          end
        end
        bus.fifo_count = 8'(fifo_q.size());
      end
      if (frame_done) begin
        done_cycles++;
        if (idx_q.size() > 0) check("frame_idx", {31'd0, frame_idx}, idx_q.pop_front());
        else check("frame_done_unexpected", 32'd1, 32'd0);
      end
      if (bus.wb_ack) begin
        bus.wb_ack = 1'b0;
      end else if (bus.wb_stb) begin
        delay = (stall_en && (ack_cnt % BL) == 3) ? 5 : 0;
        if (wait_cnt == 0) begin
          cap_adr = bus.wb_adr;
          cap_dat = bus.wb_dat_o;
        end else begin
          check("stall_adr", bus.wb_adr, cap_adr);
          check("stall_dat", bus.wb_dat_o, cap_dat);
          check("stall_rd", {31'd0, bus.fifo_r_e}, 32'd0);
        end
        if (wait_cnt >= delay) begin
          check("wr_cyc_we", {30'd0, bus.wb_cyc, bus.wb_we}, 32'd3);
          if (exp_q.size() > 0) begin
            check("wr_adr", bus.wb_adr, exp_adr_q.pop_front());
            check("wr_dat", bus.wb_dat_o, exp_q.pop_front());
          end else check("wr_unexpected", 32'd1, 32'd0);
          bus.wb_ack = 1'b1;
          ack_cnt++;
          wait_cnt = 0;
        end else wait_cnt++;
      end else if (spurious) begin
        bus.wb_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
    bus.fifo_count = 8'(fifo_q.size());
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin tick(1); n++; end
    if (ack_cnt < target) check("ack_timeout", 32'(ack_cnt), 32'(target));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cycles < target && n < budget) begin tick(1); n++; end
    if (done_cycles < target) check("done_timeout", 32'(done_cycles), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
    check({tag, "_ctl"}, {27'd0, bus.fifo_r_e, bus.wb_cyc, bus.wb_stb, bus.wb_we, frame_done}, 32'd0);
    check({tag, "_adr"}, bus.wb_adr, 32'd0);
    check({tag, "_dat"}, bus.wb_dat_o, 32'd0);
    check({tag, "_idx"}, {31'd0, frame_idx}, 32'd0);
  endtask

  initial begin
    int a0, r0, n;
    rst = 1'b1;
    enable = 1'b0;
    base_addr_0 = 32'hFFFF_FF80;
    base_addr_1 = 32'h0010_0000;
    bus.fifo_count = 8'd0;
    bus.fifo_data = 32'd0;
    bus.wb_ack = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // below burst threshold, with stray acks: nothing may start
    enable = 1'b1;
    push_words(BL - 1);
    spurious = 1;
    tick(50);
    spurious = 0;
    tick(2);
    check("thr_reads", 32'(reads), 32'd0);
    check("thr_cyc", {31'd0, bus.wb_cyc}, 32'd0);
    check("thr_state", {29'd0, dbg_state}, 32'd1);

    // first burst, ack after one cycle
    push_words(1);
    wait_acks(BL, 400);
    tick(3);
    check("b1_reads", 32'(reads), 32'(BL));
    check("b1_cyc_low", {31'd0, bus.wb_cyc}, 32'd0);
    check("b1_state", {29'd0, dbg_state}, 32'd1);
    check("b1_sb_empty", 32'(exp_q.size()), 32'd0);

    // stalled ack on word 3
    stall_en = 1;
    push_words(BL);
    wait_acks(2 * BL, 500);
    tick(3);
    stall_en = 0;
    check("b2_reads", 32'(reads), 32'(2 * BL));

    // complete the first frame, then a whole second frame
    push_words(FW - 2 * BL);
    wait_done(1, 1000);
    tick(3);
    check("f1_done_cycles", 32'(done_cycles), 32'd1);
    check("f1_state", {29'd0, dbg_state}, 32'd1);
    push_words(FW);
    wait_done(2, 2000);
    tick(3);
    check("f2_done_cycles", 32'(done_cycles), 32'd2);
    check("f2_sb_empty", 32'(exp_q.size() + idx_q.size()), 32'd0);

    // drop enable mid-burst: burst completes then the block idles
    a0 = ack_cnt;
    r0 = reads;
    push_words(2 * BL);
    wait_acks(a0 + 7, 400);
    enable = 1'b0;
    tick(200);
    check("dis_acks", 32'(ack_cnt - a0), 32'(BL));
    check("dis_reads", 32'(reads - r0), 32'(BL));
    check("dis_state", {29'd0, dbg_state}, 32'd0);
    check("dis_fifo_left", 32'(fifo_q.size()), 32'(BL));
    exp_word = 0;

    // reset during WRITE
    fifo_q.delete();
    bus.fifo_count = 8'd0;
    enable = 1'b1;
    push_words(BL);
    wait_acks(ack_cnt + 4, 400);
    n = 0;
    while (dbg_state != 3'd4 && n < 50) begin tick(1); n++; end
    check("pre_rst_write", {29'd0, dbg_state}, 32'd4);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    bus.wb_ack = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_adr_q.delete();
    idx_q.delete();
    exp_word = 0;
    exp_buf = 1'b0;
    wait_cnt = 0;
    bus.fifo_count = 8'd0;
    tick(3);

    // restart from the top of buffer 0
    a0 = ack_cnt;
    push_words(BL);
    n = 0;
    while (!bus.wb_stb && n < 50) begin tick(1); n++; end
    check("restart_adr", bus.wb_adr, base_addr_0);
    wait_acks(a0 + BL, 400);
    tick(3);
    check("restart_acks", 32'(ack_cnt - a0), 32'(BL));
    check("restart_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_in_store.md
VIDEO_IN_STORE -- requirements
Module: video_in_store

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, number of 32-bit words per bus burst (power of 2, 2..64).
REQ-002 SHALL have parameter FRAME_WORDS, default 76800, number of 32-bit words per frame (640x480 pixels, 4 pixels/word); SHALL be a multiple of BURST_LEN.
REQ-003 SHALL have port clk  input  1  single system clock (100 MHz domain); all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  capture enable; frames are stored only while high.
REQ-006 SHALL have port base_addr_0  input  32  byte base address of frame buffer 0 (word aligned).
REQ-007 SHALL have port base_addr_1  input  32  byte base address of frame buffer 1 (word aligned).
REQ-008 SHALL have port fifo_count  input  8  number of words currently in the pixel FIFO.
REQ-009 SHALL have port fifo_data  input  32  FIFO read data, valid the cycle after fifo_r_e.
REQ-010 SHALL have port fifo_r_e  output  1  FIFO read strobe, one word per high cycle.
REQ-011 SHALL have ports wb_cyc, wb_stb, wb_we  output  1 each  bus master cycle, strobe and write.
REQ-012 SHALL have ports wb_adr  output  32  byte address, and wb_dat_o  output  32  write data.
REQ-013 SHALL have port wb_ack  input  1  slave acknowledge.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last word of a frame is acknowledged.
REQ-015 SHALL have port frame_idx  output  1  index of the buffer holding the last complete frame.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, FETCH, LOAD, WRITE, DONE.
REQ-017 IDLE -> WAIT when enable=1; word counter cleared; write buffer index selected per REQ-030.
REQ-018 WAIT -> FETCH when fifo_count >= BURST_LEN; WAIT -> IDLE when enable=0 (partial frame discarded, counter cleared).
REQ-019 FETCH: fifo_r_e=1 for exactly this cycle; wb_cyc asserted from first FETCH of a burst until last ack of that burst; -> LOAD.
REQ-020 LOAD: register fifo_data into wb_dat_o; -> WRITE.
REQ-021 WRITE: wb_stb=wb_we=1, wb_adr = base + 4*word_count; hold all bus outputs stable until wb_ack.
REQ-022 On wb_ack in WRITE: word_count+1; if burst incomplete -> FETCH; if burst complete and frame incomplete -> WAIT with wb_cyc=0; if word_count reaches FRAME_WORDS -> DONE.
REQ-023 DONE: frame_done=1 for one cycle, frame_idx <= current write buffer, word_count <= 0; -> WAIT if enable=1, else IDLE.
REQ-024 enable is ignored mid-burst; a burst, once started, always completes.
REQ-025 wb_ack outside WRITE SHALL be ignored.
REQ-026 fifo_r_e SHALL never be asserted when fifo_count = 0; at most BURST_LEN reads per WAIT->FETCH decision.
REQ-027 word_count SHALL be 17 bits, unsigned; wb_adr computed modulo 2^32.

Reset
REQ-028 With RST=1 at a clk edge: state IDLE, word_count 0, fifo_r_e 0, wb_cyc/wb_stb/wb_we 0, wb_adr 0, wb_dat_o 0, frame_done 0, frame_idx 0, write buffer index 0.
REQ-029 RST asserted mid-burst SHALL drop wb_cyc/wb_stb the next cycle; no partial-frame state is retained.

Configuration
REQ-030 With VIDEO_IN_STORE_DBUF_EN defined: write buffer alternates 0,1,0,... after each DONE and base = base_addr_<index>; without it: base = base_addr_0 always, frame_idx constant 0, base_addr_1 unused.

Verification
REQ-031 Reset, enable=1, fifo_count=15 -> no fifo_r_e, wb_cyc=0 indefinitely.
REQ-032 fifo_count=16, ack 1 cycle after stb -> 16 writes, wb_adr base_addr_0+0x00..+0x3C, wb_dat_o equals FIFO words in order, wb_cyc low after burst.
REQ-033 Slave stalls ack 5 cycles on word 3 -> wb_adr/wb_dat_o/wb_stb stable all 5 cycles, no extra fifo_r_e.
REQ-034 Full frame (76800 words) with DBUF_EN, base_addr_1=0x100000 -> frame_done pulse once, frame_idx=0; next frame written from 0x100000, frame_idx=1 after it.
REQ-035 enable dropped during word 8 of a burst -> burst finishes 16 words, then IDLE, no further reads.
REQ-036 RST during WRITE -> next cycle all outputs at REQ-028 values; restart writes from base+0.
